// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg -- shared definitions for the neuron datapath.
//
// Contents:
//   NN_DATA_W / NN_FRAC_W : default fixed-point format (Q3.5, 8 bits signed)
//   neuron_state_t        : 2-bit FSM state type plus ST_* state constants
//   acc_width()           : accumulator width that holds FANIN full-precision
//                           products plus the shifted bias without overflow
//   cnt_width()           : beat counter width able to hold the value FANIN
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NN_DATA_W = 8;
    localparam int NN_FRAC_W = 5;

    // Plain vector with named constants keeps the encoding visible in
    // waveforms and in downstream tools that do not understand enums.
    typedef logic [1:0] neuron_state_t;

    localparam neuron_state_t ST_IDLE   = 2'd0;
    localparam neuron_state_t ST_ACCUM  = 2'd1;
    localparam neuron_state_t ST_FINISH = 2'd2;
    localparam neuron_state_t ST_OUTPUT = 2'd3;

    function automatic int acc_width(input int data_w, input int fanin);
        return 2 * data_w + $clog2(fanin) + 1;
    endfunction

    function automatic int cnt_width(input int fanin);
        return $clog2(fanin) + 1;
    endfunction

endpackage

// File: rtl/fx_round_sat.sv
// -----------------------------------------------------------------------------
// fx_round_sat -- combinational fixed-point narrowing stage.
//
// Takes a wide signed value carrying FRAC_W extra fractional bits, divides by
// 2**FRAC_W with round-half-up (add half an LSB, then arithmetic shift right,
// which floors), and clamps the result to the signed OUT_W range.
//
// Parameters:
//   IN_W   : width of the signed input
//   OUT_W  : width of the signed output (must be <= IN_W)
//   FRAC_W : number of fractional bits dropped
// Ports:
//   in_val  in  IN_W  : signed wide value
//   out_val out OUT_W : rounded, saturated value
//   sat     out 1     : high when the rounded value had to be clamped
// -----------------------------------------------------------------------------
module fx_round_sat #(
    parameter int IN_W   = 18,
    parameter int OUT_W  = 8,
    parameter int FRAC_W = 5
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             sat
);

    // One guard bit so that adding the rounding constant can never overflow.
    localparam int EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [EXT_W-1:0] in_ext;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    assign in_ext = {in_val[IN_W-1], in_val};

    generate
        if (FRAC_W > 0) begin : g_round
            localparam logic [EXT_W-1:0] HALF_LSB =
                {{(EXT_W - 1){1'b0}}, 1'b1} << (FRAC_W - 1);
            assign rounded = in_ext + $signed(HALF_LSB);
        end else begin : g_no_round
            assign rounded = in_ext;
        end
    endgenerate

    // Arithmetic shift floors toward minus infinity, so together with the
    // half-LSB offset ties round toward plus infinity (e.g. -31.5 -> -31).
    assign shifted = rounded >>> FRAC_W;

    always_comb begin
        out_val = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > SAT_MAX) begin
            out_val = SAT_MAX[OUT_W-1:0];
            sat     = 1'b1;
        end else if (shifted < SAT_MIN) begin
            out_val = SAT_MIN[OUT_W-1:0];
            sat     = 1'b1;
        end
    end

endmodule

// File: rtl/mac_neuron.sv
// -----------------------------------------------------------------------------
// mac_neuron -- single multiply-accumulate neuron.
//
// Accumulates FANIN full-precision weight*data products, adds a bias, rounds
// back to the DATA_W fixed-point format, saturates, and offers the result on
// a valid/ready output port.
//
// FSM: IDLE -> ACCUM (start) -> FINISH (FANIN-th beat) -> OUTPUT (one cycle)
//      -> IDLE (out_valid && out_ready). clear returns to IDLE from anywhere.
//
// Optional feature:
//   MAC_NEURON_RELU_EN : when defined, negative results become 0 after
//                        saturation (out_sat still reports the clamp).
//
// Parameters: DATA_W (operand width), FRAC_W (fraction bits), FANIN (beats).
// Ports:
//   clk        in  1      : clock, rising edge
//   reset      in  1      : asynchronous reset, active low
//   clear      in  1      : synchronous abort to IDLE, highest priority
//   start      in  1      : begin evaluation (only sampled in IDLE)
//   bias       in  DATA_W : signed bias, captured with start
//   in_valid   in  1      : weight/data beat valid
//   in_ready   out 1      : beat accepted this cycle (high only in ACCUM)
//   weight     in  DATA_W : signed weight
//   data       in  DATA_W : signed activation
//   out_valid  out 1      : result valid, held until accepted
//   out_ready  in  1      : downstream accepts result
//   out_data   out DATA_W : signed result
//   out_sat    out 1      : result was clamped, qualified by out_valid
// -----------------------------------------------------------------------------
module mac_neuron
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int FRAC_W = NN_FRAC_W,
    parameter int FANIN  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, FANIN);
    localparam int CNT_W  = cnt_width(FANIN);
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FANIN - 1);

    neuron_state_t     state_reg;
    neuron_state_t     state_next;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] bias_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_sat_reg;

    logic              beat_fire;
    logic [PROD_W-1:0] weight_ext;
    logic [PROD_W-1:0] data_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [SUM_W-1:0]  bias_ext;
    logic [SUM_W-1:0]  sum_fin;
    logic [DATA_W-1:0] rs_data;
    logic              rs_sat;
    logic [DATA_W-1:0] act_data;

    assign in_ready  = (state_reg == ST_ACCUM);
    assign beat_fire = in_valid && in_ready;

    // Sign-extend both operands to the product width; the low PROD_W bits of
    // the product are then exact for every signed input pair.
    assign weight_ext = {{DATA_W{weight[DATA_W-1]}}, weight};
    assign data_ext   = {{DATA_W{data[DATA_W-1]}}, data};
    assign prod       = weight_ext * data_ext;
    assign prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Bias is aligned with the product's 2*FRAC_W fraction by a left shift
    // of FRAC_W; one extra bit above the accumulator absorbs the carry.
    assign bias_ext = {{(SUM_W - DATA_W){bias_reg[DATA_W-1]}}, bias_reg};
    assign sum_fin  = {acc_reg[ACC_W-1], acc_reg} + (bias_ext << FRAC_W);

    fx_round_sat #(
        .IN_W   (SUM_W),
        .OUT_W  (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .in_val  (sum_fin),
        .out_val (rs_data),
        .sat     (rs_sat)
    );

`ifdef MAC_NEURON_RELU_EN
    assign act_data = rs_data[DATA_W-1] ? '0 : rs_data;
`else
    assign act_data = rs_data;
`endif

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_fire && (cnt_reg == LAST_BEAT)) begin
                        state_next = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state_next = ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            bias_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (clear) begin
                acc_reg       <= '0;
                cnt_reg       <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            acc_reg  <= '0;
                            cnt_reg  <= '0;
                            bias_reg <= bias;
                        end
                    end
                    ST_ACCUM: begin
                        // The counter stops at FANIN because the FSM leaves
                        // ACCUM on the last beat, so it never wraps.
                        if (beat_fire) begin
                            acc_reg <= acc_reg + prod_ext;
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_FINISH: begin
                        // Result registers load once and stay frozen until
                        // the next FINISH, keeping out_data stable under
                        // back-pressure.
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= act_data;
                        out_sat_reg   <= rs_sat;
                    end
                    ST_OUTPUT: begin
                        if (out_ready) begin
                            out_valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        out_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_mac_neuron.sv
// -----------------------------------------------------------------------------
// tb_mac_neuron -- scoreboard bench for mac_neuron.
//
// Two instances share clock and reset: FANIN=4 (directed and random runs with
// back-pressure, gaps, clear and reset aborts) and FANIN=1 (single-beat
// rounding cases). Drivers push the reference result into a queue when an
// evaluation is issued; monitors pop and compare whenever a result handshakes.
// -----------------------------------------------------------------------------
module tb_mac_neuron;

    localparam int DW  = 8;
    localparam int FW  = 5;
    localparam int FAN = 4;

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;

    logic          clear;
    logic          start;
    logic [DW-1:0] bias;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] weight;
    logic [DW-1:0] data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sat;

    logic          clear_1;
    logic          start_1;
    logic [DW-1:0] bias_1;
    logic          in_valid_1;
    logic          in_ready_1;
    logic [DW-1:0] weight_1;
    logic [DW-1:0] data_1;
    logic          out_valid_1;
    logic          out_ready_1;
    logic [DW-1:0] out_data_1;
    logic          out_sat_1;

    mac_neuron #(.DATA_W(DW), .FRAC_W(FW), .FANIN(FAN)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    mac_neuron #(.DATA_W(DW), .FRAC_W(FW), .FANIN(1)) u_dut_1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_1),
        .start     (start_1),
        .bias      (bias_1),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .weight    (weight_1),
        .data      (data_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .out_data  (out_data_1),
        .out_sat   (out_sat_1)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t exp_q1[$];
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: low 5 cycles per result
    int   txn_cnt = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: exact integer sum of products plus bias scaled to the same
    // fraction, divided by 2**FW rounding halves upward, clamped to DW bits.
    function automatic exp_t model(input int b, input int w[4], input int d[4], input int n);
        longint s;
        exp_t   e;
        longint hi;
        longint lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'(w[i]) * longint'(d[i]);
        end
        s += longint'(b) * (longint'(1) << FW);
        s = (s + (longint'(1) << (FW - 1))) >>> FW;
        e.sat = 1'b0;
        if (s > hi) begin
            s = hi;
            e.sat = 1'b1;
        end else if (s < lo) begin
            s = lo;
            e.sat = 1'b1;
        end
`ifdef MAC_NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        e.data = int'(s);
        return e;
    endfunction

    // out_ready driver: changes 1 time unit after the rising edge.
    initial begin
        int low_cnt;
        low_cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid) begin
                        if (low_cnt < 5) begin
                            out_ready = 1'b0;
                            low_cnt++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end else begin
                        out_ready = 1'b0;
                        low_cnt = 0;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor for the FANIN=4 instance.
    initial begin
        logic [DW-1:0] held_data;
        logic          held_sat;
        bit            held;
        exp_t          e;
        held = 1'b0;
        held_data = '0;
        held_sat = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("in_ready_low_in_output", int'(in_ready), 0);
                if (held) begin
                    check("hold_out_data", int'($signed(out_data)), int'($signed(held_data)));
                    check("hold_out_sat", int'(out_sat), int'(held_sat));
                end
                if (out_ready && !clear) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = exp_q.pop_front();
                        txn_cnt++;
                        $display("txn %0d fanin4: out_data=%0d out_sat=%0d ref_data=%0d ref_sat=%0d",
                                 txn_cnt, $signed(out_data), out_sat, e.data, e.sat);
                        check("result_data", int'($signed(out_data)), e.data);
                        check("result_sat", int'(out_sat), int'(e.sat));
                    end
                end else begin
                    held = 1'b1;
                    held_data = out_data;
                    held_sat = out_sat;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Monitor for the FANIN=1 instance (always ready).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid_1) begin
                if (exp_q1.size() == 0) begin
                    fail_now("unexpected_result_f1");
                end else begin
                    e = exp_q1.pop_front();
                    txn_cnt++;
                    $display("txn %0d fanin1: out_data=%0d out_sat=%0d ref_data=%0d ref_sat=%0d",
                             txn_cnt, $signed(out_data_1), out_sat_1, e.data, e.sat);
                    check("result_data_f1", int'($signed(out_data_1)), e.data);
                    check("result_sat_f1", int'(out_sat_1), int'(e.sat));
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || out_valid) && t < 300);
        if (t >= 300) fail_now("wait_idle_timeout");
    endtask

    task automatic do_start(input int b);
        @(negedge clk);
        start = 1'b1;
        bias = 8'(b);
        @(negedge clk);
        start = 1'b0;
        bias = 8'($urandom);
    endtask

    // One beat, preceded by 'gap' idle cycles; junk asserts start (with a
    // different bias) while the block is accumulating, which must be ignored.
    task automatic send_beat(input int w, input int d, input int gap, input bit junk);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
            weight = 8'($urandom);
            data = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        weight = 8'(w);
        data = 8'(d);
        start = junk;
        if (junk) bias = 8'($urandom);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("beat_accept_timeout");
        @(posedge clk);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every beat, 2 random.
    task automatic run_eval(input int b, input int w[4], input int d[4],
                            input int gap_mode, input bit junk_ok);
        int gap;
        bit junk;
        wait_idle();
        exp_q.push_back(model(b, w, d, FAN));
        do_start(b);
        for (int i = 0; i < FAN; i++) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            junk = junk_ok && ($urandom_range(0, 3) == 0);
            send_beat(w[i], d[i], gap, junk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        check("latency_finish_cycle", int'(out_valid), 0);
        @(negedge clk);
        check("latency_output_cycle", int'(out_valid), 1);
    endtask

    task automatic run_eval_1(input int b, input int w, input int d);
        int wa[4];
        int da[4];
        int t;
        wa = '{w, 0, 0, 0};
        da = '{d, 0, 0, 0};
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q1.size() != 0 || out_valid_1) && t < 100);
        if (t >= 100) fail_now("wait_idle_f1_timeout");
        exp_q1.push_back(model(b, wa, da, 1));
        start_1 = 1'b1;
        bias_1 = 8'(b);
        @(negedge clk);
        start_1 = 1'b0;
        in_valid_1 = 1'b1;
        weight_1 = 8'(w);
        data_1 = 8'(d);
        t = 0;
        while (!in_ready_1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("beat_accept_f1_timeout");
        @(posedge clk);
        @(negedge clk);
        in_valid_1 = 1'b0;
        check("latency_finish_cycle_f1", int'(out_valid_1), 0);
        @(negedge clk);
        check("latency_output_cycle_f1", int'(out_valid_1), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"}, int'($signed(out_data)), 0);
        check({tag, "_out_sat"}, int'(out_sat), 0);
        check({tag, "_out_valid_f1"}, int'(out_valid_1), 0);
        check({tag, "_in_ready_f1"}, int'(in_ready_1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int w4[4];
        int d4[4];
        reset = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        bias = '0;
        in_valid = 1'b0;
        weight = '0;
        data = '0;
        clear_1 = 1'b0;
        start_1 = 1'b0;
        bias_1 = '0;
        in_valid_1 = 1'b0;
        weight_1 = '0;
        data_1 = '0;
        out_ready_1 = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b1;

        // Single-beat rounding cases, including a negative result (ReLU target).
        run_eval_1(0, 1, 16);
        run_eval_1(0, -32, 32);
        run_eval_1(0, 127, 127);
        run_eval_1(-128, 1, 1);
        run_eval_1(0, 1, -16);
        for (int i = 0; i < 6; i++) run_eval_1(rnd8(), rnd8(), rnd8());

        // 2.0 from two halves of (0.5 * 2.0), padded with zero beats.
        w4 = '{16, 16, 0, 0};  d4 = '{64, 64, 0, 0};
        run_eval(0, w4, d4, 0, 1'b0);
        // 4.0 saturates to 127.
        w4 = '{32, 32, 32, 32}; d4 = '{32, 32, 32, 32};
        run_eval(0, w4, d4, 0, 1'b0);
        // Large negative sum saturates to -128.
        w4 = '{-128, -128, -128, -128}; d4 = '{127, 127, 127, 127};
        run_eval(-128, w4, d4, 0, 1'b0);
        // Toggling in_valid with the result held for 5 cycles.
        ready_mode = 2;
        w4 = '{40, 10, -50, 3}; d4 = '{-20, 30, 7, 3};
        run_eval(-5, w4, d4, 1, 1'b0);
        wait_idle();
        ready_mode = 0;

        // Abort with clear after 2 beats; a beat offered with clear is dropped.
        wait_idle();
        do_start(10);
        send_beat(50, 60, 0, 1'b0);
        send_beat(-70, 20, 0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        weight = 8'(100);
        data = 8'(100);
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        check("clear_in_ready", int'(in_ready), 0);
        check("clear_out_valid", int'(out_valid), 0);
        w4 = '{0, 0, 0, 0}; d4 = '{0, 0, 0, 0};
        run_eval(32, w4, d4, 0, 1'b0);

        // Same abort via reset.
        wait_idle();
        do_start(10);
        send_beat(50, 60, 0, 1'b0);
        send_beat(-70, 20, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        run_eval(32, w4, d4, 0, 1'b0);

        // Random evaluations with gaps, spurious start and random back-pressure.
        ready_mode = 1;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < FAN; i++) begin
                w4[i] = rnd8();
                d4[i] = rnd8();
            end
            run_eval(rnd8(), w4, d4, 2, 1'b1);
        end
        wait_idle();
        ready_mode = 0;
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("queue_drained_f1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_neuron.md
MAC_NEURON -- requirements
Module: mac_neuron

Interface
REQ-001 Parameter DATA_W, default 8: signed fixed-point width of weight, data, bias and output.
REQ-002 Parameter FRAC_W, default 5: fractional bits of every fixed-point operand (Q3.5 at default).
REQ-003 Parameter FANIN, default 16: number of weight/data beats per neuron evaluation, range 1..1024.
REQ-004 Port clk  input  1: single clock, all state on rising edge.
REQ-005 Port reset  input  1: reset, asynchronous and active-low.
REQ-006 Port clear  input  1: synchronous abort, returns block to IDLE.
REQ-007 Port start  input  1: begin evaluation, sampled only in IDLE.
REQ-008 Port bias  input  DATA_W: signed bias, captured on accepted start.
REQ-009 Port in_valid  input  1: weight/data beat valid.
REQ-010 Port in_ready  output  1: block accepts beat this cycle.
REQ-011 Port weight  input  DATA_W: signed weight.
REQ-012 Port data  input  DATA_W: signed activation.
REQ-013 Port out_valid  output  1: result valid, held until accepted.
REQ-014 Port out_ready  input  1: downstream accepts result.
REQ-015 Port out_data  output  DATA_W: signed neuron result.
REQ-016 Port out_sat  output  1: result was saturated, qualified by out_valid.

Function
REQ-017 FSM states IDLE, ACCUM, FINISH, OUTPUT; IDLE->ACCUM on start, ACCUM->FINISH on FANIN-th accepted beat, FINISH->OUTPUT after one cycle, OUTPUT->IDLE on out_valid&&out_ready.
REQ-018 in_ready high only in ACCUM; beat accepted when in_valid&&in_ready.
REQ-019 Accepted beat adds full-precision product weight*data (2*DATA_W bits) to accumulator of ACC_W = 2*DATA_W + clog2(FANIN) + 1 bits; no per-beat truncation.
REQ-020 Beat counter clog2(FANIN)+1 bits, cleared on start, increments per accepted beat; no wrap within an evaluation.
REQ-021 FINISH: add bias sign-extended and shifted left FRAC_W, arithmetic shift right FRAC_W with round-half-up, saturate to DATA_W signed range; out_sat set when clamped.
REQ-022 Latency: out_valid asserts exactly 2 cycles after the FANIN-th accepted beat.
REQ-023 out_data/out_sat stable while out_valid && !out_ready.
REQ-024 start ignored outside IDLE; start and result acceptance in same cycle: accept result, start honoured next IDLE cycle.
REQ-025 clear has priority over start, in_valid and out_ready; accumulator, counter zeroed, out_valid deasserted next cycle.
REQ-026 accumulator is never read until FANIN beats accepted; gaps in in_valid allowed, no timeout.

Reset
REQ-027 Asserted reset: state IDLE, accumulator 0, counter 0, bias register 0, out_valid 0, out_data 0, out_sat 0, in_ready 0.
REQ-028 Reset mid-evaluation discards partial sum; first cycle after deassertion is IDLE.

Configuration
REQ-029 Macro MAC_NEURON_RELU_EN defined: ReLU applied after saturation in FINISH (negative result -> 0, out_sat unaffected by ReLU).
REQ-030 Macro undefined: out_data is the signed saturated result, no activation logic synthesised.

Structure
REQ-031 Shared package nn_pkg holds state typedef neuron_state_t and fixed-point helper constants (default DATA_W, FRAC_W).
REQ-032 One sub-module fx_round_sat: combinational round-half-up shift and saturate from ACC_W to DATA_W, with sat flag.

Verification (DATA_W=8, FRAC_W=5)
REQ-033 FANIN=2, bias 0, beats (16,64),(16,64) -> out_data 64 (2.0), out_sat 0.
REQ-034 FANIN=4, bias 0, four beats (32,32) -> sum 4.0 clamps to out_data 127, out_sat 1.
REQ-035 FANIN=1, bias 0, beat (1,16) -> product 16, rounds to out_data 1; beat (-32,32) -> out_data -32 without macro, 0 with MAC_NEURON_RELU_EN.
REQ-036 FANIN=4, in_valid toggling every other cycle, out_ready low 5 cycles -> correct sum, out_data held stable, in_ready low throughout OUTPUT.
REQ-037 clear asserted after 2 of 4 beats, then fresh start with bias 32 and four (0,0) beats -> out_data 32; same abort via reset gives identical result.
